// File: rtl/psum_accumulator.sv
// psum_accumulator: folds ACC_LEN unsigned words into one sum through a ripple-carry adder,
// with a sticky carry-out flag and valid/ready ports on both sides.
module psum_ripple_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic w_c;
  always_comb begin
    w_c = 1'b0;
    o_sum = '0;
    for (int i = 0; i < W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end
endmodule

module psum_accumulator #(
  parameter int WORD_WIDTH = 32,
  parameter int ACC_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_ovf
);
  localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  typedef enum logic {ACC, DONE} state_t;
  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_acc, r_out_data, w_a, w_sum;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf, r_out_ovf, r_out_valid, w_cout, w_first, w_ovf_next;
  assign in_ready   = (r_state == ACC) && !clear && !reset;
  assign w_first    = r_cnt == '0;
  assign w_a        = w_first ? '0 : r_acc;
  assign w_ovf_next = w_first ? w_cout : (r_ovf | w_cout);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  psum_ripple_adder #(.W(WORD_WIDTH)) u_add (
    .i_a   (w_a),
    .i_b   (in_data),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );
  // in ACC with clear and reset low, in_ready is 1, so in_valid alone means accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACC;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_state == DONE) begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
        r_state     <= ACC;
      end
    end else if (clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      if (r_cnt == LAST) begin
        r_out_data  <= w_sum;
        r_out_ovf   <= w_ovf_next;
        r_out_valid <= 1'b1;
        r_cnt       <= '0;
        r_state     <= DONE;
      end else begin
        r_acc <= w_sum;
        r_ovf <= w_ovf_next;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Sequential partial-sum accumulator that sits directly downstream of the ripple-carry `Adder` in the systolic-array datapath. It accepts a stream of unsigned words over a valid/ready handshake and folds each word into a running sum with one `Adder` instance. After a fixed number of words it presents the total, plus a sticky carry-out overflow flag, on a valid/ready output port. Typical use is reducing per-PE partial products into one output word per array column.

## Interface
- `WORD_WIDTH`, 32: data width of input, accumulator and result (unsigned).
- `ACC_LEN`, 4: words summed per result; legal range 1..65535.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: reset, synchronous and active-high.
- `clear`  input  1: synchronous abort of the partial accumulation.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: block can accept a word this cycle.
- `in_data`  input  WORD_WIDTH: operand word.
- `out_valid`  output  1: result is valid.
- `out_ready`  input  1: consumer takes the result this cycle.
- `out_data`  output  WORD_WIDTH: accumulated sum, modulo 2^WORD_WIDTH.
- `out_ovf`  output  1: at least one carry-out occurred while forming `out_data`.

## Operation
- The block has two states:
  - ACC: collecting words.
  - DONE: holding a result.
- The block keeps these registers:
  - `acc`, WORD_WIDTH bits.
  - `ovf`, 1 bit, sticky.
  - `cnt`, enough bits for 0..ACC_LEN-1.
  - `out_data`, `out_ovf`, `out_valid`.
- `in_ready = (state==ACC) && !clear && !reset`. This is combinational from the state and inputs; no other combinational input-to-output path exists.
- Accept means `in_valid && in_ready` at a rising edge.
- Adder operands:
  - a = `acc` when `cnt != 0`, else 0.
  - b = `in_data`.
  - Outputs are `sum` (WORD_WIDTH bits) and `cout`.
  - Arithmetic is unsigned and wraps; no saturation.
- On accept with `cnt < ACC_LEN-1`: `acc <= sum`; `ovf <= (cnt==0 ? cout : ovf|cout)`; `cnt <= cnt+1`.
- On accept with `cnt == ACC_LEN-1`:
  - `out_data <= sum`, `out_ovf <= (cnt==0 ? cout : ovf|cout)`, `out_valid <= 1`.
  - `cnt <= 0`, state becomes DONE.
- When ACC_LEN=1, every accepted word passes straight to DONE with `out_ovf=0`.
- In DONE:
  - `in_ready=0`.
  - When `out_ready` is high: `out_valid <= 0`, state becomes ACC.
  - While `out_ready` is low: `out_data` and `out_ovf` hold stable.
- `clear` in ACC: `cnt <= 0` and `ovf <= 0`; the current word is not accepted.
- `clear` in DONE: ignored; the pending result is still delivered.
- `clear` and `out_ready` in the same DONE cycle: result delivered, state returns to ACC, `cnt` stays 0.
- `reset` overrides everything. All registers return to their reset values, including a mid-accumulation or pending result; in-flight data is lost.

## Timing
- Reset values: state=ACC, `cnt=0`, `acc=0`, `ovf=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`.
- `in_ready` is 0 during every cycle `reset` is high, and 1 in the first cycle after reset deasserts (unless `clear` is high).
- Latency: `out_valid` rises in the cycle after the edge that accepts the ACC_LEN-th word.
- Minimum spacing between results is ACC_LEN+1 cycles: ACC_LEN accepts plus one DONE cycle with `out_ready=1`.
- `in_valid` gaps are allowed. Partial state holds indefinitely, and `cnt` advances only on accept.
- Output handshake: once `out_valid` is high, it stays high with stable data until `out_ready` is sampled high.
- Producer rule: `in_data` is sampled only on an accept edge. Changes to it while `in_ready=0` have no effect.

## Test plan
- **Basic sum.** WORD_WIDTH=8, ACC_LEN=4; inputs 1,2,3,4 back-to-back with `out_ready=1` -> `out_data=10`, `out_ovf=0`, `out_valid` high one cycle after the 4th accept, `in_ready` high again the next cycle.
- **Overflow.** WORD_WIDTH=8, ACC_LEN=4; inputs 200,100,0,0 -> `out_data=44`, `out_ovf=1`. Then inputs 1,1,1,1 -> `out_data=4`, `out_ovf=0`, confirming the sticky flag clears per result.
- **Backpressure.** After the result 10 is formed, hold `out_ready=0` for 5 cycles while `in_valid=1`, `in_data=9` -> `out_valid`=1 and `out_data`=10 stable, `in_ready`=0, no word accepted. Raise `out_ready` -> one transfer, then 9 accepted as the first word of the next group.
- **Clear mid-group.** Accept 7,7; assert `clear` together with `in_valid=1`, `in_data=50` -> 50 not accepted, no output. Then 5,5,5,5 -> `out_data=20`, `out_ovf=0`.
- **Reset mid-operation.** Accept 3 words, pulse `reset` one cycle -> all outputs 0, `in_ready=0` during reset and 1 after. Then 2,2,2,2 -> `out_data=8`.
- **ACC_LEN=1 with stalls.** Inputs 255,1 with random `in_valid` gaps and `out_ready` toggling -> results 255 then 1, each with `out_ovf=0`, in order, none dropped or duplicated.
